// File: rtl/bus_cmd_master_if.sv
// Signal bundle for bus_cmd_master: inbound/outbound byte streams plus the
// peripheral bus (A/WD/WE/RD) and status flags.
interface bus_cmd_master_if #(
   parameter int ADDR_W = 5
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [ADDR_W-1:0] A;
   logic [31:0]       WD;
   logic              WE;
   logic [31:0]       RD;
   logic              busy;
   logic              err;

   modport master (
      input  rx_data, rx_valid, tx_ready, RD,
      output rx_ready, tx_data, tx_valid, A, WD, WE, busy, err
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, RD,
      input  rx_ready, tx_data, tx_valid, A, WD, WE, busy, err
   );
endinterface

// File: rtl/bus_cmd_master.sv
// Byte-stream command initiator: decodes 'W'/'R' frames from the rx stream,
// performs one bus write or sampled read, and streams the response on tx.
module bus_cmd_master #(
   parameter int ADDR_W  = 5,
   parameter int RD_WAIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   bus_cmd_master_if.master bus
);

   localparam logic [7:0] OP_WR    = 8'h57;
   localparam logic [7:0] OP_RD    = 8'h52;
   localparam logic [7:0] RESP_ERR = 8'h45;
   localparam logic [7:0] RESP_OK  = 8'h4B;
   localparam int         WAIT_W   = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      DATA   = 3'd2,
      BUS_WR = 3'd3,
      BUS_RD = 3'd4,
      RESP   = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic              op_wr_r, op_wr_s;
   logic [7:0]        addr_r, addr_s;
   logic [31:0]       shift_r, shift_s;
   logic [1:0]        cnt_r, cnt_s;
   logic [WAIT_W-1:0] wait_r, wait_s;
   logic [31:0]       resp_r, resp_s;
   logic [2:0]        rem_r, rem_s;
   logic [ADDR_W-1:0] a_r, a_s;
   logic [31:0]       wd_r, wd_s;
   logic              we_r, we_s;
   logic              tx_valid_r, tx_valid_s;
   logic [7:0]        tx_data_r, tx_data_s;
   logic              err_r, err_s;
   logic              rx_ready_s;
   logic              rx_fire_s;

   // Address byte is legal only when every bit above the bus width is zero.
   function automatic logic addr_ok(input logic [7:0] b);
      return (b >> ADDR_W) == 8'd0;
   endfunction

   assign rx_ready_s = ~rst & ((state_r == IDLE) | (state_r == ADDR) | (state_r == DATA));
   assign rx_fire_s  = bus.rx_valid & rx_ready_s;

   assign bus.rx_ready = rx_ready_s;
   assign bus.busy     = (state_r != IDLE);
   assign bus.A        = a_r;
   assign bus.WD       = wd_r;
   assign bus.WE       = we_r;
   assign bus.tx_valid = tx_valid_r;
   assign bus.tx_data  = tx_data_r;
   assign bus.err      = err_r;

   // Next-state and next-register values for the whole command engine.
   always_comb begin
      state_s    = state_r;
      op_wr_s    = op_wr_r;
      addr_s     = addr_r;
      shift_s    = shift_r;
      cnt_s      = cnt_r;
      wait_s     = wait_r;
      resp_s     = resp_r;
      rem_s      = rem_r;
      a_s        = a_r;
      wd_s       = wd_r;
      we_s       = 1'b0;
      tx_valid_s = tx_valid_r;
      tx_data_s  = tx_data_r;
      err_s      = 1'b0;

      case (state_r)
         IDLE: begin
            if (rx_fire_s) begin
               if ((bus.rx_data == OP_WR) || (bus.rx_data == OP_RD)) begin
                  op_wr_s = (bus.rx_data == OP_WR);
                  state_s = ADDR;
               end else begin
                  state_s    = RESP;
                  resp_s     = {24'd0, RESP_ERR};
                  rem_s      = 3'd1;
                  tx_valid_s = 1'b1;
                  tx_data_s  = RESP_ERR;
                  err_s      = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end

         ADDR: begin
            if (rx_fire_s) begin
               addr_s = bus.rx_data;
               if (op_wr_r) begin
                  cnt_s   = 2'd0;
                  state_s = DATA;
               end else if (addr_ok(bus.rx_data)) begin
                  a_s     = bus.rx_data[ADDR_W-1:0];
                  wait_s  = '0;
                  state_s = BUS_RD;
               end else begin
                  state_s    = RESP;
                  resp_s     = {24'd0, RESP_ERR};
                  rem_s      = 3'd1;
                  tx_valid_s = 1'b1;
                  tx_data_s  = RESP_ERR;
                  err_s      = 1'b1;
               end
            end else begin
               state_s = ADDR;
            end
         end

         DATA: begin
            if (rx_fire_s) begin
               shift_s = {bus.rx_data, shift_r[31:8]};
               cnt_s   = cnt_r + 2'd1;
               if (cnt_r == 2'd3) begin
                  // Bus outputs are loaded only for a legal address, so a bad
                  // write frame leaves A/WD untouched.
                  if (addr_ok(addr_r)) begin
                     a_s     = addr_r[ADDR_W-1:0];
                     wd_s    = {bus.rx_data, shift_r[31:8]};
                     we_s    = 1'b1;
                     state_s = BUS_WR;
                  end else begin
                     state_s    = RESP;
                     resp_s     = {24'd0, RESP_ERR};
                     rem_s      = 3'd1;
                     tx_valid_s = 1'b1;
                     tx_data_s  = RESP_ERR;
                     err_s      = 1'b1;
                  end
               end else begin
                  state_s = DATA;
               end
            end else begin
               state_s = DATA;
            end
         end

         BUS_WR: begin
            state_s    = RESP;
            resp_s     = {24'd0, RESP_OK};
            rem_s      = 3'd1;
            tx_valid_s = 1'b1;
            tx_data_s  = RESP_OK;
         end

         BUS_RD: begin
            if (wait_r == WAIT_W'(RD_WAIT)) begin
               state_s    = RESP;
               resp_s     = bus.RD;
               rem_s      = 3'd4;
               tx_valid_s = 1'b1;
               tx_data_s  = bus.RD[7:0];
            end else begin
               wait_s = wait_r + 1'b1;
            end
         end

         RESP: begin
            if (tx_valid_r & bus.tx_ready) begin
               if (rem_r == 3'd1) begin
                  tx_valid_s = 1'b0;
                  state_s    = IDLE;
               end else begin
                  rem_s     = rem_r - 3'd1;
                  resp_s    = {8'd0, resp_r[31:8]};
                  tx_data_s = resp_r[15:8];
               end
            end else begin
               state_s = RESP;
            end
         end

         default: begin
            state_s    = IDLE;
            tx_valid_s = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_wr_r    <= 1'b0;
         addr_r     <= 8'd0;
         shift_r    <= 32'd0;
         cnt_r      <= 2'd0;
         wait_r     <= '0;
         resp_r     <= 32'd0;
         rem_r      <= 3'd0;
         a_r        <= '0;
         wd_r       <= 32'd0;
         we_r       <= 1'b0;
         tx_valid_r <= 1'b0;
         tx_data_r  <= 8'd0;
         err_r      <= 1'b0;
      end else begin
         op_wr_r    <= op_wr_s;
         addr_r     <= addr_s;
         shift_r    <= shift_s;
         cnt_r      <= cnt_s;
         wait_r     <= wait_s;
         resp_r     <= resp_s;
         rem_r      <= rem_s;
         a_r        <= a_s;
         wd_r       <= wd_s;
         we_r       <= we_s;
         tx_valid_r <= tx_valid_s;
         tx_data_r  <= tx_data_s;
         err_r      <= err_s;
      end
   end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master (ADDR_W=5, RD_WAIT=1); outputs are
// sampled 1ns after the rising edge.
module tb_bus_cmd_master;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   we_cnt;
   int   err_cnt;
   int   we_base;
   int   err_base;
   logic [31:0] word;

   bus_cmd_master_if #(.ADDR_W(5)) bif ();

   bus_cmd_master #(.ADDR_W(5), .RD_WAIT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bif.WE === 1'b1) we_cnt++;
      if (bif.err === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      while (bif.rx_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("rx_accept", {31'd0, bif.rx_ready}, 32'd1);
      step();
      bif.rx_valid = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0; we_cnt = 0; err_cnt = 0;
      rst = 1'b1;
      bif.rx_data = 8'd0; bif.rx_valid = 1'b0;
      bif.tx_ready = 1'b1; bif.RD = 32'd0;
      step(); step();

      chk("rst_tx_valid", {31'd0, bif.tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, bif.tx_data}, 32'd0);
      chk("rst_A", {27'd0, bif.A}, 32'd0);
      chk("rst_WD", bif.WD, 32'd0);
      chk("rst_WE", {31'd0, bif.WE}, 32'd0);
      chk("rst_err", {31'd0, bif.err}, 32'd0);
      chk("rst_busy", {31'd0, bif.busy}, 32'd0);
      chk("rst_rx_ready", {31'd0, bif.rx_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_rx_ready", {31'd0, bif.rx_ready}, 32'd1);
      step();

      // Write 57 04 78 56 34 12
      send_byte(8'h57); send_byte(8'h04); send_byte(8'h78);
      send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      chk("wr_WE", {31'd0, bif.WE}, 32'd1);
      chk("wr_A", {27'd0, bif.A}, 32'd4);
      chk("wr_WD", bif.WD, 32'h12345678);
      chk("wr_rx_ready", {31'd0, bif.rx_ready}, 32'd0);
      chk("wr_tx_valid_early", {31'd0, bif.tx_valid}, 32'd0);
      step();
      chk("wr_WE_off", {31'd0, bif.WE}, 32'd0);
      chk("wr_tx_valid", {31'd0, bif.tx_valid}, 32'd1);
      chk("wr_tx_data", {24'd0, bif.tx_data}, 32'h4B);
      step();
      chk("wr_tx_done", {31'd0, bif.tx_valid}, 32'd0);
      chk("wr_busy", {31'd0, bif.busy}, 32'd0);
      chk("wr_we_count", we_cnt, 32'd1);

      // Read 52 08 with RD=DEADBEEF
      we_base = we_cnt;
      bif.RD = 32'hDEADBEEF;
      send_byte(8'h52); send_byte(8'h08);
      chk("rd_A0", {27'd0, bif.A}, 32'd8);
      chk("rd_tx_valid0", {31'd0, bif.tx_valid}, 32'd0);
      step();
      chk("rd_A1", {27'd0, bif.A}, 32'd8);
      chk("rd_tx_valid1", {31'd0, bif.tx_valid}, 32'd0);
      step();
      word = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         chk("rd_tx_valid", {31'd0, bif.tx_valid}, 32'd1);
         chk("rd_byte", {24'd0, bif.tx_data}, {24'd0, word[8*i +: 8]});
         step();
      end
      chk("rd_tx_done", {31'd0, bif.tx_valid}, 32'd0);
      chk("rd_busy", {31'd0, bif.busy}, 32'd0);
      chk("rd_no_we", we_cnt, we_base);

      // Bad command byte
      err_base = err_cnt;
      send_byte(8'h00);
      chk("bad_tx_valid", {31'd0, bif.tx_valid}, 32'd1);
      chk("bad_tx_data", {24'd0, bif.tx_data}, 32'h45);
      chk("bad_err", {31'd0, bif.err}, 32'd1);
      step();
      chk("bad_err_off", {31'd0, bif.err}, 32'd0);
      chk("bad_tx_done", {31'd0, bif.tx_valid}, 32'd0);
      chk("bad_err_count", err_cnt - err_base, 32'd1);
      chk("bad_no_we", we_cnt, we_base);

      // Write to out-of-range address 0x20
      err_base = err_cnt;
      send_byte(8'h57); send_byte(8'h20); send_byte(8'h01);
      send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      chk("oor_tx_data", {24'd0, bif.tx_data}, 32'h45);
      chk("oor_tx_valid", {31'd0, bif.tx_valid}, 32'd1);
      chk("oor_err", {31'd0, bif.err}, 32'd1);
      chk("oor_WE", {31'd0, bif.WE}, 32'd0);
      chk("oor_A", {27'd0, bif.A}, 32'd8);
      chk("oor_WD", bif.WD, 32'h12345678);
      step();
      chk("oor_tx_done", {31'd0, bif.tx_valid}, 32'd0);
      chk("oor_err_count", err_cnt - err_base, 32'd1);
      chk("oor_no_we", we_cnt, we_base);

      // Read 52 03 with tx back-pressure
      bif.tx_ready = 1'b0;
      bif.RD = 32'hDEADBEEF;
      send_byte(8'h52); send_byte(8'h03);
      step(); step();
      bif.RD = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_tx_valid", {31'd0, bif.tx_valid}, 32'd1);
         chk("bp_tx_data", {24'd0, bif.tx_data}, 32'hEF);
         chk("bp_rx_ready", {31'd0, bif.rx_ready}, 32'd0);
         step();
      end
      bif.tx_ready = 1'b1;
      step();
      word = 32'hDEADBEEF;
      for (int i = 1; i < 4; i++) begin
         chk("bp_byte", {24'd0, bif.tx_data}, {24'd0, word[8*i +: 8]});
         chk("bp_tx_valid_run", {31'd0, bif.tx_valid}, 32'd1);
         step();
      end
      chk("bp_tx_done", {31'd0, bif.tx_valid}, 32'd0);

      // Reset mid-frame, then a fresh read
      we_base = we_cnt;
      send_byte(8'h57); send_byte(8'h04); send_byte(8'h78);
      rst = 1'b1;
      #1;
      chk("mrst_tx_valid", {31'd0, bif.tx_valid}, 32'd0);
      chk("mrst_WE", {31'd0, bif.WE}, 32'd0);
      chk("mrst_A", {27'd0, bif.A}, 32'd0);
      chk("mrst_busy", {31'd0, bif.busy}, 32'd0);
      step(); step();
      rst = 1'b0;
      step();
      bif.RD = 32'hCAFEF00D;
      send_byte(8'h52); send_byte(8'h00);
      chk("mrst_rd_A", {27'd0, bif.A}, 32'd0);
      step(); step();
      word = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         chk("mrst_rd_byte", {24'd0, bif.tx_data}, {24'd0, word[8*i +: 8]});
         step();
      end
      chk("mrst_tx_done", {31'd0, bif.tx_valid}, 32'd0);
      chk("mrst_no_we", we_cnt, we_base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
